apb_slave_mem: RTL and testbench

APB completer (slave) with internal register-file storage. It receives PSEL/PENABLE/PWRITE/PADDR/PWDATA from the APB master bridge, one instance per PSELx, and returns PRDATA/PREADY/PSLVERR. It inserts a fixed number of wait states and flags errors for out-of-range addresses and APB protocol violations.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_slave_mem_if.sv | 28 ++
 rtl/apb_slave_regfile.sv | 29 ++
 rtl/apb_slave_mem.sv | 118 +++++++++++
 tb/tb_apb_slave_mem.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the one-hot completer FSM states.
package apb_pkg;

  localparam int DATAWIDTH = 8;
  localparam int ADDRWIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    ERROR  = 3'b100
  } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
interface apb_slave_mem_if
  import apb_pkg::*;
#(
  parameter int DW = DATAWIDTH,
  parameter int AW = ADDRWIDTH
);

  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// Register-file storage: async clear, synchronous enabled write, combinational read.
module apb_slave_regfile #(
  parameter int DATAWIDTH = 8,
  parameter int MEMDEPTH  = 64,
  parameter int IW        = $clog2(MEMDEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IW-1:0]        waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [IW-1:0]        raddr,
  output logic [DATAWIDTH-1:0] rdata
);

  logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];

  // NOTE: every word is cleared by reset, so this array maps to flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEMDEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with fixed wait states, address-range and protocol error detection.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATAWIDTH  = apb_pkg::DATAWIDTH,
  parameter int ADDRWIDTH  = apb_pkg::ADDRWIDTH,
  parameter int MEMDEPTH   = 64,
  parameter int WAITCYCLES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_slave_mem_if.slave   bus
);

  localparam int IW = $clog2(MEMDEPTH);
  localparam int CW = (WAITCYCLES > 0) ? $clog2(WAITCYCLES + 1) : 1;
  localparam logic [CW-1:0]        WAIT_INIT = CW'(WAITCYCLES);
  localparam logic [ADDRWIDTH:0]   DEPTH_L   = (ADDRWIDTH + 1)'(MEMDEPTH);

  apb_state_e           state_q,    state_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDRWIDTH-1:0] addr_q,     addr_d;
  logic                 write_q,    write_d;
  logic [DATAWIDTH-1:0] wdata_q,    wdata_d;
  logic [DATAWIDTH-1:0] rdata_q,    rdata_d;

  logic                 pready, pslverr, mem_we;
  logic                 paddr_ok, addr_err, stab_err;
  logic [DATAWIDTH-1:0] mem_rdata;

  assign paddr_ok = {1'b0, bus.PADDR} < DEPTH_L;
  assign addr_err = !({1'b0, addr_q} < DEPTH_L);
  assign stab_err = (bus.PADDR != addr_q) || (bus.PWRITE != write_q) ||
                    (write_q && (bus.PWDATA != wdata_q));

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    pready     = 1'b0;
    pslverr    = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          addr_d     = bus.PADDR;
          write_d    = bus.PWRITE;
          wdata_d    = bus.PWDATA;
          wait_cnt_d = WAIT_INIT;
          rdata_d    = paddr_ok ? mem_rdata : '0;
          state_d    = ACCESS;
        end else if (bus.PSEL) begin
          state_d = ERROR;
        end
      end
      ACCESS: begin
        pready  = (wait_cnt_q == '0);
        pslverr = pready && (addr_err || stab_err);
        if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (bus.PENABLE && pready) begin
          // pslverr already covers out-of-range, so a clean completion is always writable
          mem_we  = write_q && !pslverr;
          state_d = IDLE;
        end
      end
      ERROR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  apb_slave_regfile #(
    .DATAWIDTH (DATAWIDTH),
    .MEMDEPTH  (MEMDEPTH),
    .IW        (IW)
  ) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .waddr (addr_q[IW-1:0]),
    .wdata (wdata_q),
    .raddr (bus.PADDR[IW-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;
  assign bus.PRDATA  = (state_q == ACCESS && pready && !write_q && !pslverr) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem with a two-wait and a zero-wait instance on one clock.
module tb_apb_slave_mem;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       psel, penable, pwrite, sel_w0;
  logic [7:0] paddr, pwdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    string      tag;
  } exp_t;
  exp_t sb[$];

  apb_slave_mem_if bus_w2 ();
  apb_slave_mem_if bus_w0 ();

  assign bus_w2.PSEL    = psel & ~sel_w0;
  assign bus_w2.PENABLE = penable;
  assign bus_w2.PWRITE  = pwrite;
  assign bus_w2.PADDR   = paddr;
  assign bus_w2.PWDATA  = pwdata;
  assign bus_w0.PSEL    = psel & sel_w0;
  assign bus_w0.PENABLE = penable;
  assign bus_w0.PWRITE  = pwrite;
  assign bus_w0.PADDR   = paddr;
  assign bus_w0.PWDATA  = pwdata;

  apb_slave_mem #(.MEMDEPTH(64), .WAITCYCLES(2)) dut_w2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_w2.slave));
  apb_slave_mem #(.MEMDEPTH(64), .WAITCYCLES(0)) dut_w0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_w0.slave));

  always #5 PCLK = ~PCLK;

  logic       obs_ready, obs_err;
  logic [7:0] obs_rdata;
  assign obs_ready = sel_w0 ? bus_w0.PREADY  : bus_w2.PREADY;
  assign obs_err   = sel_w0 ? bus_w0.PSLVERR : bus_w2.PSLVERR;
  assign obs_rdata = sel_w0 ? bus_w0.PRDATA  : bus_w2.PRDATA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pready"},  32'(obs_ready), 32'd0);
    check({tag, "_pslverr"}, 32'(obs_err),   32'd0);
    check({tag, "_prdata"},  32'(obs_rdata), 32'd0);
  endtask

  // One transfer starting on the next edge; optional PADDR change after the first wait cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp_rdata, input logic exp_err, input int exp_waits,
                      input string tag, input bit chg_en = 1'b0, input logic [7:0] chg_addr = 8'h00);
    int   waits;
    exp_t e;
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    sb.push_back('{exp_rdata, exp_err, tag});
    @(posedge PCLK); #1;
    penable = 1'b1;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (obs_ready) break;
      waits++;
      if (chg_en && waits == 1) begin
        @(posedge PCLK); #1;
        paddr = chg_addr;
      end
    end
    check({tag, "_ready"}, 32'(obs_ready), 32'd1);
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    e = sb.pop_front();
    check({e.tag, "_prdata"},  32'(obs_rdata), 32'(e.rdata));
    check({e.tag, "_pslverr"}, 32'(obs_err),   32'(e.err));
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; sel_w0 = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // reset then idle, both instances
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      sel_w0 = 1'b0; #0 check_quiet("idle_w2");
      sel_w0 = 1'b1; #0 check_quiet("idle_w0");
    end
    sel_w0 = 1'b0;

    // two wait states: write then immediate read of the same word
    xfer(1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 2, "w2_wr05");
    xfer(1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 2, "w2_rd05");
    go_idle();

    // zero-wait back-to-back, including the last valid word
    sel_w0 = 1'b1;
    xfer(1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 0, "w0_wr00");
    xfer(1'b1, 8'h3F, 8'h22, 8'h00, 1'b0, 0, "w0_wr3f");
    xfer(1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 0, "w0_rd00");
    xfer(1'b0, 8'h3F, 8'h00, 8'h22, 1'b0, 0, "w0_rd3f");

    // first out-of-range address
    xfer(1'b1, 8'h40, 8'hFF, 8'h00, 1'b1, 0, "w0_wr40");
    xfer(1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 0, "w0_rd40");
    xfer(1'b0, 8'h3F, 8'h00, 8'h22, 1'b0, 0, "w0_rd3f_again");
    go_idle();
    sel_w0 = 1'b0;

    // access phase without setup phase
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h00;
    @(negedge PCLK);
    check("noset_pre_pready", 32'(obs_ready), 32'd0);
    @(negedge PCLK);
    check("noset_pready",  32'(obs_ready), 32'd1);
    check("noset_pslverr", 32'(obs_err),   32'd1);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check_quiet("noset_after");

    // PADDR unstable during access
    xfer(1'b1, 8'h05, 8'h00, 8'h00, 1'b1, 2, "w2_unstable", 1'b1, 8'h06);
    xfer(1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 2, "w2_rd05_kept");
    xfer(1'b0, 8'h06, 8'h00, 8'h00, 1'b0, 2, "w2_rd06_kept");
    go_idle();

    // master abort in wait cycle 1
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h33;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("abort_wait0", 32'(obs_ready), 32'd0);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check("abort_wait1", 32'(obs_ready), 32'd0);
    @(negedge PCLK);
    check_quiet("abort_idle");
    xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 2, "w2_rd10_aborted");
    go_idle();

    // reset during the access phase of a zero-wait write
    sel_w0 = 1'b1;
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'h5A;
    @(posedge PCLK); #1;
    penable = 1'b1;
    #1 check("rst_pre_pready", 32'(obs_ready), 32'd1);
    #1 PRESETn = 1'b0;
    #1 check("rst_pready",  32'(obs_ready), 32'd0);
    check("rst_pslverr", 32'(obs_err), 32'd0);
    #1 PRESETn = 1'b1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check_quiet("rst_idle");
    xfer(1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 0, "w0_rd07_lost");
    xfer(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0, "w0_rd00_cleared");
    go_idle();
    sel_w0 = 1'b0;
    xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 2, "w2_rd05_cleared");
    go_idle();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
